simon_cifra_nucleo: RTL and testbench



---
 rtl/simon_pkg.sv | 27 ++
 rtl/simon_rodada.sv | 18 +
 rtl/simon_cifra_nucleo.sv | 91 +++++++++
 tb/tb_simon_cifra_nucleo.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
// Shared constants, state encoding and rotation helpers for the Simon 128/128 core.
package simon_pkg;

  parameter int unsigned WORD_W = 64;
  parameter int unsigned ROUNDS = 68;
  parameter int unsigned CNT_W  = 7;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  // FSM state encoding (2 bits, code 3 unused and recovers to idle)
  typedef logic [1:0] state_t;
  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

  // Left rotation over one word; s must be in 1..WORD_W-1
  function automatic word_t rotl(input word_t v, input int unsigned s);
    return (v << s) | (v >> (WORD_W - s));
  endfunction

  // Simon round nonlinearity: (x<<<1 & x<<<8) ^ x<<<2
  function automatic word_t simon_f(input word_t v);
    return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
  endfunction

endpackage

// File: rtl/simon_rodada.sv
// One combinational Simon round: x' = y ^ f(x) ^ k, y' = x.
module simon_rodada
  import simon_pkg::*;
(
  input  logic [WORD_W-1:0] x_i,
  input  logic [WORD_W-1:0] y_i,
  input  logic [WORD_W-1:0] k_i,
  output logic [WORD_W-1:0] x_next_o,
  output logic [WORD_W-1:0] y_next_o
);

  // Feistel step
  always_comb begin
    x_next_o = y_i ^ simon_f(x_i) ^ k_i;
    y_next_o = x_i;
  end

endmodule

// File: rtl/simon_cifra_nucleo.sv
// Iterative Simon 128/128 encryption core, one round per clock. Drives the
// key-schedule enable so the schedule sits at round key 0 whenever a run begins.
module simon_cifra_nucleo
  import simon_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [2*WORD_W-1:0] pt_i,
  input  logic [WORD_W-1:0]   kj_i,
  output logic                key_en_o,
  output logic                busy_o,
  output logic                done_o,
  output logic [2*WORD_W-1:0] ct_o
);

  localparam cnt_t LastRound = cnt_t'(ROUNDS - 1);

  state_t state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  word_t  x_q, x_d;
  word_t  y_q, y_d;
  word_t  x_rnd, y_rnd;

  simon_rodada u_rodada (
    .x_i      (x_q),
    .y_i      (y_q),
    .k_i      (kj_i),
    .x_next_o (x_rnd),
    .y_next_o (y_rnd)
  );

  // Next-state, counter and datapath selection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          x_d     = pt_i[2*WORD_W-1:WORD_W];
          y_d     = pt_i[WORD_W-1:0];
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        x_d   = x_rnd;
        y_d   = y_rnd;
        cnt_d = cnt_q + cnt_t'(1);
        // The edge that applies the last round also leaves RUN
        if (cnt_q == LastRound) begin
          cnt_d   = cnt_q;
          state_d = StDone;
        end
      end
      StDone: begin
        // start_i deliberately ignored here; earliest restart is from idle
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Outputs are pure state decodes; ct_o holds until the next accepted start
  always_comb begin
    key_en_o = (state_q == StRun);
    busy_o   = (state_q == StRun) || (state_q == StDone);
    done_o   = (state_q == StDone);
    ct_o     = {x_q, y_q};
  end

endmodule

// File: tb/tb_simon_cifra_nucleo.sv
// Bench for simon_cifra_nucleo: behavioural key schedule drives kj_i from key_en_o,
// table of directed vectors plus random ones against a software Simon model,
// and hand-written sequences for start-while-busy, held start and mid-run reset.
module tb_simon_cifra_nucleo;

  localparam logic [127:0] KatKey = 128'h0f0e0d0c0b0a0908_0706050403020100;
  localparam logic [127:0] KatPt  = 128'h63736564207372656c6c657661727420;
  localparam logic [127:0] KatCt  = 128'h49681b1e1e54fe3f65aa832af84e0bbc;
  localparam logic [127:0] AltPt  = 128'hdeadbeef_01234567_89abcdef_cafef00d;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_i;
  logic [127:0] pt_i;
  logic [63:0]  kj_i;
  logic         key_en_o;
  logic         busy_o;
  logic         done_o;
  logic [127:0] ct_o;

  logic [63:0] rk [68];
  int          kidx = 0;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  simon_cifra_nucleo dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .pt_i     (pt_i),
    .kj_i     (kj_i),
    .key_en_o (key_en_o),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .ct_o     (ct_o)
  );

  // Key-schedule stand-in: reloads k0 while enable is low, advances while high
  always @(posedge clk) begin
    if (!key_en_o) kidx <= 0;
    else           kidx <= kidx + 1;
  end
  assign kj_i = (kidx < 68) ? rk[kidx] : 64'h0;

  function automatic logic [63:0] rol(input logic [63:0] v, input int s);
    return (v << s) | (v >> (64 - s));
  endfunction

  task automatic set_key(input logic [127:0] key);
    logic [63:0] zc;
    logic [63:0] tmp;
    zc    = 64'h7369F885192C0EF5;
    rk[0] = key[63:0];
    rk[1] = key[127:64];
    for (int i = 0; i < 66; i++) begin
      tmp       = rol(rk[i+1], 61);
      tmp       = tmp ^ rol(tmp, 63);
      rk[i + 2] = 64'hFFFF_FFFF_FFFF_FFFC ^ {63'b0, zc[i % 62]} ^ rk[i] ^ tmp;
    end
  endtask

  function automatic logic [127:0] ref_enc(input logic [127:0] pt);
    logic [63:0] x, y, t;
    x = pt[127:64];
    y = pt[63:0];
    for (int r = 0; r < 68; r++) begin
      t = x;
      x = y ^ ((rol(x, 1) & rol(x, 8)) ^ rol(x, 2)) ^ rk[r];
      y = t;
    end
    return {x, y};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, got, exp);
    end
  endtask

  // Starts one block and waits for done_o; lat counts edges from the start edge
  task automatic run_block(input logic [127:0] pt, output logic [127:0] ct,
                           output int lat, output int ken);
    @(negedge clk);
    pt_i    = pt;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    lat     = 1;
    ken     = 0;
    while (!done_o && lat < 200) begin
      if (key_en_o) ken++;
      @(negedge clk);
      lat++;
    end
    ct = ct_o;
  endtask

  typedef struct {
    string        nm;
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] ct;
    bit           use_model;
  } vec_t;

  vec_t         vecs[4];
  logic [127:0] ct, rkey, rpt;
  int           lat, ken, dones, prev_cyc, cyc, seen, busy_seen;

  initial begin
    vecs[0] = '{nm: "kat",       key: KatKey, pt: KatPt, ct: KatCt, use_model: 1'b0};
    vecs[1] = '{nm: "kat_again", key: KatKey, pt: KatPt, ct: KatCt, use_model: 1'b0};
    vecs[2] = '{nm: "zero",      key: '0,     pt: '0,    ct: '0,    use_model: 1'b1};
    vecs[3] = '{nm: "kat_key_alt_pt", key: KatKey, pt: AltPt, ct: '0, use_model: 1'b1};

    rst_n   = 1'b0;
    start_i = 1'b0;
    pt_i    = '0;
    set_key(KatKey);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_ct", ct_o, '0);
    chk("reset_flags", {busy_o, done_o, key_en_o}, '0);
    repeat (3) @(negedge clk);
    chk("idle_flags", {busy_o, done_o, key_en_o}, '0);

    // Directed table
    for (int v = 0; v < 4; v++) begin
      set_key(vecs[v].key);
      if (vecs[v].use_model) vecs[v].ct = ref_enc(vecs[v].pt);
      run_block(vecs[v].pt, ct, lat, ken);
      chk({vecs[v].nm, "_ct"}, ct, vecs[v].ct);
      chk({vecs[v].nm, "_latency"}, lat, 69);
      chk({vecs[v].nm, "_key_en_cycles"}, ken, 68);
      chk({vecs[v].nm, "_done_busy"}, {done_o, busy_o}, 2'b11);
      @(negedge clk);
      chk({vecs[v].nm, "_after_done"}, {done_o, busy_o, key_en_o}, '0);
      chk({vecs[v].nm, "_ct_held"}, ct_o, vecs[v].ct);
    end

    // Random keys/plaintexts against the model
    for (int n = 0; n < 200; n++) begin
      rkey = {$urandom, $urandom, $urandom, $urandom};
      rpt  = {$urandom, $urandom, $urandom, $urandom};
      set_key(rkey);
      run_block(rpt, ct, lat, ken);
      chk("random_ct", ct, ref_enc(rpt));
    end

    // start_i pulsed during RUN and DONE must be ignored
    set_key(KatKey);
    @(negedge clk);
    pt_i    = KatPt;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    lat     = 1;
    while (!done_o && lat < 200) begin
      start_i = (lat == 10);
      pt_i    = (lat == 10) ? AltPt : KatPt;
      @(negedge clk);
      lat++;
    end
    chk("ignore_latency", lat, 69);
    chk("ignore_ct_at_done", ct_o, KatCt);
    start_i = 1'b1;
    pt_i    = AltPt;
    @(negedge clk);
    start_i   = 1'b0;
    dones     = 0;
    busy_seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (done_o) dones++;
      if (busy_o) busy_seen++;
      @(negedge clk);
    end
    chk("ignore_extra_done", dones, 0);
    chk("ignore_busy_after", busy_seen, 0);
    chk("ignore_ct_held", ct_o, KatCt);

    // start_i held high: one block every 70 cycles
    @(negedge clk);
    pt_i     = KatPt;
    start_i  = 1'b1;
    cyc      = 0;
    seen     = 0;
    prev_cyc = 0;
    while (seen < 3 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (done_o) begin
        chk("held_ct", ct_o, KatCt);
        if (seen > 0) chk("held_period", cyc - prev_cyc, 70);
        prev_cyc = cyc;
        seen++;
      end
    end
    start_i = 1'b0;
    chk("held_pulse_count", seen, 3);
    repeat (2) @(negedge clk);
    chk("held_stop_idle", busy_o, 1'b0);

    // Reset during RUN aborts
    @(negedge clk);
    pt_i    = KatPt;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    repeat (29) @(negedge clk);
    chk("pre_reset_busy", busy_o, 1'b1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_ct", ct_o, '0);
    chk("midrst_flags", {busy_o, done_o, key_en_o}, '0);
    dones = 0;
    for (int i = 0; i < 80; i++) begin
      if (done_o) dones++;
      @(negedge clk);
    end
    chk("midrst_no_done", dones, 0);
    run_block(KatPt, ct, lat, ken);
    chk("midrst_rerun_ct", ct, KatCt);
    chk("midrst_rerun_latency", lat, 69);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
